// File: rtl/disk_track_loader.sv
// disk_track_loader: per-drive whole-track SD block sequencer feeding the Disk II track RAM.
// Build with `define DISK_WRITEBACK_EN to write dirty tracks back before a reload.
module disk_track_loader #(
    parameter int DRIVES         = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_W        = 6
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic [DRIVES*TRACK_W-1:0]         track,
    input  logic [DRIVES-1:0]                 img_mounted,
    input  logic [DRIVES-1:0]                 img_present,
    input  logic [DRIVES-1:0]                 dirty_set,
    input  logic                              sd_ack,
    output logic [31:0]                       sd_lba,
    output logic                              sd_rd,
    output logic                              sd_wr,
    output logic [$clog2(DRIVES):0]           sd_drive,
    output logic [$clog2(SECS_PER_TRACK)-1:0] track_sec,
    output logic                              cpu_wait,
    output logic                              busy
);
    localparam int SEC_W = $clog2(SECS_PER_TRACK);
    localparam int DRV_W = $clog2(DRIVES) + 1;
    localparam int IDX_W = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
`ifdef DISK_WRITEBACK_EN
        S_WB   = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DRIVES-1:0]  valid_q, valid_d;
    logic [DRIVES-1:0]  mount_pend_q, mount_pend_d;
    logic [TRACK_W-1:0] cur_track_q [DRIVES];
    logic [TRACK_W-1:0] cur_track_d [DRIVES];
    logic [TRACK_W-1:0] trk_in [DRIVES];
    logic [TRACK_W-1:0] new_trk_q, new_trk_d;
    logic [IDX_W-1:0]   drv_q, drv_d, pick;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [31:0]        lba_q, lba_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               ack_q;
    logic [DRIVES-1:0]  need;
    logic               any_need, ack_rise, ack_fall, last_blk, blk_done;

`ifdef DISK_WRITEBACK_EN
    logic [DRIVES-1:0]  dirty_q, dirty_d;
    // Remembers a controller write that lands while the old track is being written back.
    logic               redirty_q, redirty_d;
`else
    logic               unused_dirty;
    assign unused_dirty = ^dirty_set;
`endif

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] trk);
        return 32'(trk) * 32'(SECS_PER_TRACK);
    endfunction

    always_comb begin
        for (int d = 0; d < DRIVES; d++) begin
            trk_in[d] = track[d*TRACK_W +: TRACK_W];
            need[d]   = img_present[d] &
                        (~valid_q[d] | (trk_in[d] != cur_track_q[d]) | mount_pend_q[d]);
        end
        // Lowest-numbered drive wins when several need service.
        pick = '0;
        for (int d = DRIVES - 1; d >= 0; d--) begin
            if (need[d]) pick = IDX_W'(d);
        end
    end

    assign any_need = |need;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign last_blk = (sec_q == LAST_SEC);
    assign blk_done = ack_fall & last_blk;

    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_need) begin
`ifdef DISK_WRITEBACK_EN
                    if (!mount_pend_q[pick] && dirty_q[pick]) state_d = S_WB;
                    else                                      state_d = S_RD;
`else
                    state_d = S_RD;
`endif
                end
            end
`ifdef DISK_WRITEBACK_EN
            S_WB:    if (blk_done) state_d = S_RD;
`endif
            S_RD:    if (blk_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        cpu_wait = (state_q != S_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q      <= '0;
            mount_pend_q <= '0;
            for (int d = 0; d < DRIVES; d++) cur_track_q[d] <= '0;
            new_trk_q    <= '0;
            drv_q        <= '0;
            sec_q        <= '0;
            lba_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ack_q        <= 1'b0;
`ifdef DISK_WRITEBACK_EN
            dirty_q      <= '0;
            redirty_q    <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            mount_pend_q <= mount_pend_d;
            cur_track_q  <= cur_track_d;
            new_trk_q    <= new_trk_d;
            drv_q        <= drv_d;
            sec_q        <= sec_d;
            lba_q        <= lba_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ack_q        <= sd_ack;
`ifdef DISK_WRITEBACK_EN
            dirty_q      <= dirty_d;
            redirty_q    <= redirty_d;
`endif
        end
    end

    always_comb begin
        valid_d      = valid_q;
        mount_pend_d = mount_pend_q;
        cur_track_d  = cur_track_q;
        new_trk_d    = new_trk_q;
        drv_d        = drv_q;
        sec_d        = sec_q;
        lba_d        = lba_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
`ifdef DISK_WRITEBACK_EN
        dirty_d      = dirty_q;
        redirty_d    = redirty_q;
`endif
        if (state_q == S_IDLE) begin
            if (any_need) begin
                new_trk_d = trk_in[pick];
                drv_d     = pick;
                sec_d     = '0;
                rd_d      = 1'b1;
                lba_d     = lba_of(trk_in[pick]);
                if (mount_pend_q[pick]) begin
                    // A fresh image makes whatever the RAM holds irrelevant, so no write-back.
                    mount_pend_d[pick] = 1'b0;
`ifdef DISK_WRITEBACK_EN
                    dirty_d[pick]      = 1'b0;
`endif
                end
`ifdef DISK_WRITEBACK_EN
                else if (dirty_q[pick]) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b1;
                    lba_d     = lba_of(cur_track_q[pick]);
                    redirty_d = 1'b0;
                end
`endif
            end
        end else if (state_q == S_DONE) begin
            cur_track_d[drv_q] = new_trk_q;
            valid_d[drv_q]     = 1'b1;
        end else begin
            if (ack_rise) begin
                if (last_blk) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                end
                lba_d = lba_q + 32'd1;
            end
            if (ack_fall) begin
                sec_d = last_blk ? '0 : sec_q + SEC_W'(1);
`ifdef DISK_WRITEBACK_EN
                if (last_blk && state_q == S_WB) begin
                    lba_d          = lba_of(new_trk_q);
                    rd_d           = 1'b1;
                    dirty_d[drv_q] = redirty_q;
                end
`endif
            end
`ifdef DISK_WRITEBACK_EN
            if (state_q == S_WB && dirty_set[drv_q]) redirty_d = 1'b1;
`endif
        end
        for (int d = 0; d < DRIVES; d++) begin
            if (img_mounted[d])  mount_pend_d[d] = 1'b1;
`ifdef DISK_WRITEBACK_EN
            if (dirty_set[d])    dirty_d[d]      = 1'b1;
`endif
            if (!img_present[d]) valid_d[d]      = 1'b0;
        end
    end

    assign sd_lba    = lba_q;
    assign sd_rd     = rd_q;
    assign sd_wr     = wr_q;
    assign sd_drive  = DRV_W'(drv_q);
    assign track_sec = sec_q;

endmodule
